// File: rtl/io_map_pkg.sv
// Shared address map for the CPU I/O port bank: default bases, status register
// offsets and the elaboration-time overlap helper.
package io_map_pkg;

   localparam int MAX_PORTS     = 16;

   localparam int DEF_OUT_BASE  = 'hE0;
   localparam int DEF_IN_BASE   = 'hF0;
   localparam int DEF_STAT_BASE = 'hD0;

   localparam int STAT_CHG_LO   = 0;
   localparam int STAT_CHG_HI   = 1;
   localparam int STAT_MASK_LO  = 2;
   localparam int STAT_MASK_HI  = 3;
   localparam int STAT_REGS     = 4;

   function automatic bit ranges_overlap(input int a_base, input int a_len,
                                         input int b_base, input int b_len);
      return (a_base < b_base + b_len) && (b_base < a_base + a_len);
   endfunction

endpackage

// File: rtl/io_sync.sv
// Single-bit multi-flop synchroniser for asynchronous port inputs.
module io_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[STAGES-2:0], d};
      end
   end

   assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped I/O port bank: registered outputs, synchronised inputs,
// sticky W1C change flags with per-port mask and a single level interrupt.
module io_port_bank
   import io_map_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int N_PORTS     = 16,
   parameter int OUT_BASE    = DEF_OUT_BASE,
   parameter int IN_BASE     = DEF_IN_BASE,
   parameter int STAT_BASE   = DEF_STAT_BASE,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [ADDR_W-1:0]           addr,
   input  logic                        wr_en,
   input  logic [DATA_W-1:0]           wr_data,
   output logic [DATA_W-1:0]           rd_data,
   input  logic [N_PORTS*DATA_W-1:0]   port_in,
   output logic [N_PORTS*DATA_W-1:0]   port_out,
   output logic                        irq
);

   localparam int TOTAL_W = N_PORTS * DATA_W;
   localparam int ARM_MAX = SYNC_STAGES + 1;
   localparam int ARM_W   = $clog2(ARM_MAX + 1);
   localparam logic [MAX_PORTS-1:0] PORT_MASK = MAX_PORTS'((33'h1 << N_PORTS) - 33'h1);

   if (N_PORTS < 1 || N_PORTS > MAX_PORTS || SYNC_STAGES < 2 || DATA_W < 8 ||
       ranges_overlap(OUT_BASE, N_PORTS, IN_BASE, N_PORTS) ||
       ranges_overlap(OUT_BASE, N_PORTS, STAT_BASE, STAT_REGS) ||
       ranges_overlap(IN_BASE, N_PORTS, STAT_BASE, STAT_REGS)) begin : g_param_check
      $error("io_port_bank: illegal parameter set");
   end

   logic [TOTAL_W-1:0]   sync_in;
   logic [TOTAL_W-1:0]   prev_reg;
   logic [TOTAL_W-1:0]   port_out_reg;
   logic [MAX_PORTS-1:0] chg_flag_reg;
   logic [MAX_PORTS-1:0] chg_flag_next;
   logic [MAX_PORTS-1:0] irq_mask_reg;
   logic [MAX_PORTS-1:0] chg_set;
   logic [MAX_PORTS-1:0] w1c;
   logic [ARM_W-1:0]     arm_cnt_reg;
   logic                 armed;
   logic                 irq_reg;

   genvar gi;

   for (gi = 0; gi < TOTAL_W; gi++) begin : g_sync
      io_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk   (clk),
         .reset (reset),
         .d     (port_in[gi]),
         .q     (sync_in[gi])
      );
   end

   // Detection waits until prev_reg holds a real synchronised value, so the
   // reset-to-live transition never raises a flag.
   assign armed = (arm_cnt_reg == ARM_W'(ARM_MAX));

   for (gi = 0; gi < MAX_PORTS; gi++) begin : g_chg
      if (gi < N_PORTS) begin : g_live
         assign chg_set[gi] = armed &&
            (sync_in[gi*DATA_W +: DATA_W] != prev_reg[gi*DATA_W +: DATA_W]);
      end else begin : g_dead
         assign chg_set[gi] = 1'b0;
      end
   end

   always_comb begin
      w1c = '0;
      if (wr_en && addr == ADDR_W'(STAT_BASE + STAT_CHG_LO)) begin
         w1c[7:0] = wr_data[7:0];
      end
      if (wr_en && addr == ADDR_W'(STAT_BASE + STAT_CHG_HI)) begin
         w1c[15:8] = wr_data[7:0];
      end
   end

   // A new change in the same cycle as its W1C keeps the flag set.
   assign chg_flag_next = ((chg_flag_reg & ~w1c) | chg_set) & PORT_MASK;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         port_out_reg <= '0;
         prev_reg     <= '0;
         chg_flag_reg <= '0;
         irq_mask_reg <= '0;
         arm_cnt_reg  <= '0;
         irq_reg      <= 1'b0;
      end else begin
         prev_reg     <= sync_in;
         chg_flag_reg <= chg_flag_next;
         irq_reg      <= |(chg_flag_reg & irq_mask_reg);
         if (!armed) begin
            arm_cnt_reg <= arm_cnt_reg + 1'b1;
         end
         for (int k = 0; k < N_PORTS; k++) begin
            if (wr_en && addr == ADDR_W'(OUT_BASE + k)) begin
               port_out_reg[k*DATA_W +: DATA_W] <= wr_data;
            end
         end
         if (wr_en && addr == ADDR_W'(STAT_BASE + STAT_MASK_LO)) begin
            irq_mask_reg[7:0] <= wr_data[7:0] & PORT_MASK[7:0];
         end
         if (wr_en && addr == ADDR_W'(STAT_BASE + STAT_MASK_HI)) begin
            irq_mask_reg[15:8] <= wr_data[7:0] & PORT_MASK[15:8];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (addr == ADDR_W'(OUT_BASE + k)) begin
            rd_data = port_out_reg[k*DATA_W +: DATA_W];
         end
         if (addr == ADDR_W'(IN_BASE + k)) begin
            rd_data = sync_in[k*DATA_W +: DATA_W];
         end
      end
      if (addr == ADDR_W'(STAT_BASE + STAT_CHG_LO)) begin
         rd_data = DATA_W'(chg_flag_reg[7:0]);
      end
      if (addr == ADDR_W'(STAT_BASE + STAT_CHG_HI)) begin
         rd_data = DATA_W'(chg_flag_reg[15:8]);
      end
      if (addr == ADDR_W'(STAT_BASE + STAT_MASK_LO)) begin
         rd_data = DATA_W'(irq_mask_reg[7:0]);
      end
      if (addr == ADDR_W'(STAT_BASE + STAT_MASK_HI)) begin
         rd_data = DATA_W'(irq_mask_reg[15:8]);
      end
   end

   assign port_out = port_out_reg;
   assign irq      = irq_reg;

endmodule

// File: tb/tb_io_port_bank.sv
// Bench for io_port_bank: directed scenarios plus random traffic, checked
// against an edge-counted behavioural model of the port bank.
module tb_io_port_bank;

   localparam int S = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [7:0]   addr = 8'h00;
   logic         wr_en = 1'b0;
   logic [7:0]   wr_data = 8'h00;
   logic [7:0]   rd_data;
   logic [127:0] port_in = '0;
   logic [127:0] port_out;
   logic         irq;

   logic [7:0]   rd_data4;
   logic [31:0]  port_in4 = '0;
   logic [31:0]  port_out4;
   logic         irq4;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Model state
   logic [127:0] m_out;
   logic [15:0]  m_flag;
   logic [15:0]  m_mask;
   logic         m_irq;
   logic [127:0] in_hist [0:4095];
   int           edge_n;

   always #5 clk = ~clk;

   io_port_bank #(.N_PORTS(16), .SYNC_STAGES(S)) dut (
      .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
      .rd_data(rd_data), .port_in(port_in), .port_out(port_out), .irq(irq)
   );

   io_port_bank #(.N_PORTS(4), .SYNC_STAGES(S)) dut4 (
      .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
      .rd_data(rd_data4), .port_in(port_in4), .port_out(port_out4), .irq(irq4)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total_cnt = total_cnt + 1;
      assert (obs === exp) pass_cnt = pass_cnt + 1;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // An input value first sampled at edge m becomes readable after edge m+S-1;
   // a difference between consecutive sampled values (edge 1 is the baseline)
   // raises the flag at the edge S later.
   function automatic logic [7:0] model_read(input logic [7:0] a);
      int i;
      i = int'(a);
      if (i >= 'hE0 && i <= 'hEF) return m_out[(i-'hE0)*8 +: 8];
      if (i >= 'hF0 && i <= 'hFF) begin
         if (edge_n >= S) return in_hist[edge_n-S+1][(i-'hF0)*8 +: 8];
         return 8'h00;
      end
      if (i == 'hD0) return m_flag[7:0];
      if (i == 'hD1) return m_flag[15:8];
      if (i == 'hD2) return m_mask[7:0];
      if (i == 'hD3) return m_mask[15:8];
      return 8'h00;
   endfunction

   task automatic model_edge();
      logic [15:0] set;
      logic [15:0] clr;
      logic        new_irq;
      int          i;
      edge_n = edge_n + 1;
      in_hist[edge_n] = port_in;
      set = '0;
      clr = '0;
      if (edge_n >= S + 2) begin
         for (int p = 0; p < 16; p++) begin
            if (in_hist[edge_n-S][p*8 +: 8] != in_hist[edge_n-S-1][p*8 +: 8]) set[p] = 1'b1;
         end
      end
      new_irq = |(m_flag & m_mask);
      if (wr_en) begin
         i = int'(addr);
         if (i >= 'hE0 && i <= 'hEF) m_out[(i-'hE0)*8 +: 8] = wr_data;
         if (i == 'hD0) clr[7:0] = wr_data;
         if (i == 'hD1) clr[15:8] = wr_data;
         if (i == 'hD2) m_mask[7:0] = wr_data;
         if (i == 'hD3) m_mask[15:8] = wr_data;
      end
      m_flag = (m_flag & ~clr) | set;
      m_irq = new_irq;
   endtask

   task automatic tick(input logic [7:0] a, input logic we, input logic [7:0] d);
      addr = a;
      wr_en = we;
      wr_data = d;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      wr_en = 1'b0;
      chk("port_out", port_out, m_out);
      chk("irq", {127'b0, irq}, {127'b0, m_irq});
   endtask

   task automatic check_rd(input logic [7:0] a);
      addr = a;
      wr_en = 1'b0;
      #1;
      chk($sformatf("rd_%02h", a), {120'b0, rd_data}, {120'b0, model_read(a)});
   endtask

   task automatic model_clear();
      m_out = '0;
      m_flag = '0;
      m_mask = '0;
      m_irq = 1'b0;
      edge_n = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(8'h00, 1'b0, 8'h00);
   endtask

   initial begin
      logic [7:0] a;
      int b;
      model_clear();
      port_in = {$urandom, $urandom, $urandom, $urandom};
      port_in[15:8] = 8'h00;
      #12;
      @(negedge clk);
      reset = 1'b0;

      // Reset state and stable inputs
      chk("rst_port_out", port_out, 128'h0);
      chk("rst_irq", {127'b0, irq}, 128'h0);
      idle(8);
      check_rd(8'hD0);
      chk("no_flag_lo", {120'b0, rd_data}, 128'h0);
      check_rd(8'hD1);
      chk("no_flag_hi", {120'b0, rd_data}, 128'h0);
      check_rd(8'hF3);

      // Output writes
      tick(8'hE0, 1'b1, 8'h0F);
      chk("out0", {120'b0, port_out[7:0]}, {120'b0, 8'h0F});
      tick(8'hE3, 1'b1, 8'hA5);
      chk("out3", {120'b0, port_out[31:24]}, {120'b0, 8'hA5});
      chk("out_others", port_out & ~128'hFF0000FF, 128'h0);
      check_rd(8'hE3);

      // Input synchroniser latency
      port_in[15:8] = 8'h02;
      tick(8'h00, 1'b0, 8'h00);
      check_rd(8'hF1);
      chk("sync_early", {120'b0, rd_data}, 128'h0);
      tick(8'h00, 1'b0, 8'h00);
      check_rd(8'hF1);
      chk("sync_ready", {120'b0, rd_data}, {120'b0, 8'h02});
      idle(4);

      // Change detect and interrupt masking
      tick(8'hD2, 1'b1, 8'h01);
      tick(8'hD0, 1'b1, 8'hFF);
      port_in[8] = ~port_in[8];
      idle(S + 2);
      check_rd(8'hD0);
      chk("flag1_set", {127'b0, rd_data[1]}, 128'h1);
      chk("irq_masked", {127'b0, irq}, 128'h0);
      port_in[0] = ~port_in[0];
      idle(S + 2);
      check_rd(8'hD0);
      chk("flag0_set", {127'b0, rd_data[0]}, 128'h1);
      chk("irq_on", {127'b0, irq}, 128'h1);

      // W1C racing with a fresh change on the same port
      port_in[0] = ~port_in[0];
      idle(S);
      tick(8'hD0, 1'b1, 8'h01);
      check_rd(8'hD0);
      chk("race_flag", {127'b0, rd_data[0]}, 128'h1);
      chk("race_irq", {127'b0, irq}, 128'h1);
      idle(2);
      tick(8'hD0, 1'b1, 8'h01);
      check_rd(8'hD0);
      chk("w1c_flag", {127'b0, rd_data[0]}, 128'h0);
      tick(8'h00, 1'b0, 8'h00);
      chk("w1c_irq", {127'b0, irq}, 128'h0);

      // Async reset mid-run with all outputs high
      for (int k = 0; k < 16; k++) tick(8'hE0 + 8'(k), 1'b1, 8'hFF);
      port_in[0] = ~port_in[0];
      idle(S + 2);
      chk("pre_rst_irq", {127'b0, irq}, 128'h1);
      addr = 8'hD0;
      #2;
      reset = 1'b1;
      #1;
      chk("async_port_out", port_out, 128'h0);
      chk("async_irq", {127'b0, irq}, 128'h0);
      chk("async_rd_d0", {120'b0, rd_data}, 128'h0);
      model_clear();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle(6);
      check_rd(8'hD0);

      // Reduced port count instance
      tick(8'hE5, 1'b1, 8'h3C);
      chk("n4_e5_ignored", {96'b0, port_out4}, 128'h0);
      tick(8'hE1, 1'b1, 8'h11);
      chk("n4_e1", {96'b0, port_out4}, {96'b0, 32'h00001100});
      tick(8'hD3, 1'b1, 8'hFF);
      tick(8'hD2, 1'b1, 8'hFF);
      tick(8'hD1, 1'b1, 8'hFF);
      addr = 8'hD3; #1; chk("n4_rd_d3", {120'b0, rd_data4}, 128'h0);
      addr = 8'hD2; #1; chk("n4_rd_d2", {120'b0, rd_data4}, {120'b0, 8'h0F});
      addr = 8'hD1; #1; chk("n4_rd_d1", {120'b0, rd_data4}, 128'h0);
      addr = 8'hF5; #1; chk("n4_rd_f5", {120'b0, rd_data4}, 128'h0);
      addr = 8'hE5; #1; chk("n4_rd_e5", {120'b0, rd_data4}, 128'h0);
      addr = 8'hE1; #1; chk("n4_rd_e1", {120'b0, rd_data4}, {120'b0, 8'h11});

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            b = $urandom_range(0, 127);
            port_in[b] = ~port_in[b];
         end
         case ($urandom_range(0, 7))
            0, 1, 2: a = 8'hE0 + 8'($urandom_range(0, 15));
            3, 4:    a = 8'hD0 + 8'($urandom_range(0, 3));
            5:       a = 8'hF0 + 8'($urandom_range(0, 15));
            default: a = 8'($urandom_range(0, 255));
         endcase
         tick(a, 1'($urandom_range(0, 1)), 8'($urandom));
         case ($urandom_range(0, 3))
            0:       check_rd(8'hD0 + 8'($urandom_range(0, 3)));
            1:       check_rd(8'hF0 + 8'($urandom_range(0, 15)));
            2:       check_rd(8'hE0 + 8'($urandom_range(0, 15)));
            default: check_rd(8'($urandom_range(0, 255)));
         endcase
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
